// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot iteration engine: FSM encoding and
// fixed-point constants for the signed 2.(WIDTH-2) format.
package mandelbrot_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int FRAC_BITS     = DEFAULT_WIDTH - 2;
  localparam int ONE           = 1 << FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration controller: holds z and c for the external mandelbrot_alu, counts
// iterations until escape or limit, and hands the result downstream.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // Both handshakes: a transfer happens on a rising edge where valid and
  // ready are both high; valid holds its payload stable until that edge.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] in_max_iter,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_count,
  output logic              out_escaped,
  output logic [WIDTH-1:0]  alu_cr,
  output logic [WIDTH-1:0]  alu_ci,
  output logic [WIDTH-1:0]  alu_zr,
  output logic [WIDTH-1:0]  alu_zi,
  input  logic [WIDTH-1:0]  alu_zr_next,
  input  logic [WIDTH-1:0]  alu_zi_next,
  input  logic              alu_size,
  input  logic              alu_overflow,
  output state_t            dbg_state
);

  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
  logic [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
  logic [ITER_W-1:0] iter_q, iter_d, max_q, max_d, count_q, count_d;
  logic              escaped_q, escaped_d;
  logic              escape;
  logic              clear;

  assign escape = alu_size | alu_overflow;

  always_comb begin
    state_d   = state_q;
    cr_d      = cr_q;
    ci_d      = ci_q;
    zr_d      = zr_q;
    zi_d      = zi_q;
    iter_d    = iter_q;
    max_d     = max_q;
    count_d   = count_q;
    escaped_d = escaped_q;
    clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cr_d   = in_cr;
          ci_d   = in_ci;
          max_d  = in_max_iter;
          zr_d   = '0;
          zi_d   = '0;
          iter_d = '0;
          if (in_max_iter == '0) begin
            state_d   = ST_DONE;
            count_d   = '0;
            escaped_d = 1'b0;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        // On escape z keeps the last in-range value; the ALU result is dropped.
        if (abort) begin
          clear = 1'b1;
        end else if (escape) begin
          state_d   = ST_DONE;
          count_d   = iter_q;
          escaped_d = 1'b1;
        end else if (iter_q == max_q - ITER_ONE) begin
          state_d   = ST_DONE;
          count_d   = max_q;
          escaped_d = 1'b0;
        end else begin
          zr_d   = alu_zr_next;
          zi_d   = alu_zi_next;
          iter_d = iter_q + ITER_ONE;
        end
      end
      ST_DONE: begin
        // abort outranks a simultaneous handshake: the pixel is abandoned.
        if (abort) begin
          clear = 1'b1;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        clear = 1'b1;
      end
    endcase

    if (clear) begin
      state_d   = ST_IDLE;
      cr_d      = '0;
      ci_d      = '0;
      zr_d      = '0;
      zi_d      = '0;
      iter_d    = '0;
      max_d     = '0;
      count_d   = '0;
      escaped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cr_q      <= '0;
      ci_q      <= '0;
      zr_q      <= '0;
      zi_q      <= '0;
      iter_q    <= '0;
      max_q     <= '0;
      count_q   <= '0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cr_q      <= cr_d;
      ci_q      <= ci_d;
      zr_q      <= zr_d;
      zi_q      <= zi_d;
      iter_q    <= iter_d;
      max_q     <= max_d;
      count_q   <= count_d;
      escaped_q <= escaped_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_count   = count_q;
  assign out_escaped = escaped_q;
  assign alu_cr      = cr_q;
  assign alu_ci      = ci_q;
  assign alu_zr      = zr_q;
  assign alu_zi      = zi_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Bench for mandelbrot_iter_ctrl with a behavioural step ALU attached;
// directed pixels feed an expected queue checked by an output monitor.
module tb_mandelbrot_iter_ctrl;
  import mandelbrot_pkg::*;

  localparam int WIDTH  = 8;
  localparam int ITER_W = 8;
  localparam int EW     = 40;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_cr = '0, in_ci = '0;
  logic [ITER_W-1:0] in_max_iter = '0;
  logic              abort = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ITER_W-1:0] out_count;
  logic              out_escaped;
  logic [WIDTH-1:0]  alu_cr, alu_ci, alu_zr, alu_zi;
  logic [WIDTH-1:0]  alu_zr_next, alu_zi_next;
  logic              alu_size, alu_overflow;
  state_t            dbg_state;

  mandelbrot_iter_ctrl #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cr(in_cr), .in_ci(in_ci), .in_max_iter(in_max_iter),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped),
    .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
    .alu_zr_next(alu_zr_next), .alu_zi_next(alu_zi_next),
    .alu_size(alu_size), .alu_overflow(alu_overflow),
    .dbg_state(dbg_state)
  );

  // Step unit: z' = z^2 + c in 2.6 format; size = |z|^2 > 4, overflow = z' out of range.
  int m_zr, m_zi, m_cr, m_ci, m_nr, m_ni;
  always_comb begin
    m_zr = int'($signed(alu_zr));
    m_zi = int'($signed(alu_zi));
    m_cr = int'($signed(alu_cr));
    m_ci = int'($signed(alu_ci));
    m_nr = ((m_zr * m_zr) >>> 6) - ((m_zi * m_zi) >>> 6) + m_cr;
    m_ni = 2 * ((m_zr * m_zi) >>> 6) + m_ci;
    alu_zr_next  = m_nr[7:0];
    alu_zi_next  = m_ni[7:0];
    alu_size     = (m_zr * m_zr + m_zi * m_zi) > 4 * 64 * 64;
    alu_overflow = (m_nr > 127) || (m_nr < -128) || (m_ni > 127) || (m_ni < -128);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        ov_prev = 1'b0, or_prev = 1'b0, esc_prev = 1'b0;
  logic [7:0]  cnt_prev = '0;
  int          rise_cyc = 0;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise_cyc = cyc;
    if (out_valid && ov_prev && !or_prev) begin
      check("hold_count", out_count, cnt_prev);
      check("hold_escaped", out_escaped, esc_prev);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got count=%0d escaped=%0d expected none", out_count, out_escaped);
      end else begin
        e = exp_q.pop_front();
        check("out_count", out_count, int'(e[7:0]));
        check("out_escaped", out_escaped, int'(e[8]));
        check("valid_cycle", rise_cyc, int'(e[39:9]));
      end
    end
    ov_prev  = out_valid;
    or_prev  = out_ready;
    cnt_prev = out_count;
    esc_prev = out_escaped;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_in_ready: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  // lat = cycles from accept edge to first out_valid cycle; push=0 for abandoned pixels.
  task automatic send(input int cr, input int ci, input int max_iter,
                      input int exp_cnt, input int exp_esc, input int lat, input bit push);
    wait_ready();
    in_valid    = 1'b1;
    in_cr       = cr[7:0];
    in_ci       = ci[7:0];
    in_max_iter = max_iter[7:0];
    tick();
    in_valid = 1'b0;
    if (push) exp_q.push_back({31'(cyc + lat - 1), exp_esc[0], exp_cnt[7:0]});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_escaped"}, out_escaped, 0);
    check({tag, "_alu_zr"}, alu_zr, 0);
    check({tag, "_alu_cr"}, alu_cr, 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    check_cleared("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", in_ready, 1);

    send(0, 0, 16, 16, 0, 17, 1);
    send(64, 0, 16, 1, 1, 3, 1);
    send(-128, 0, 16, 1, 1, 3, 1);
    send(37, -90, 0, 0, 0, 1, 1);
    send(64, 0, 1, 1, 0, 2, 1);
    send(0, 64, 5, 5, 0, 6, 1);

    // Backpressure: result held 5 cycles while a competing coordinate is offered.
    wait_ready();
    out_ready = 1'b0;
    send(64, 0, 16, 1, 1, 3, 1);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_cr    = 8'd5;
      tick();
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_handshake_in_ready", in_ready, 1);
    check("post_handshake_out_valid", out_valid, 0);

    // Abort while iter=3: z has reached 22 for c=0.25.
    send(16, 0, 16, 0, 0, 0, 0);
    tick(); tick(); tick();
    check("abort_pre_alu_zr", alu_zr, 22);
    check("abort_pre_alu_cr", alu_cr, 16);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_cleared("abort");
    send(64, 0, 16, 1, 1, 3, 1);

    // Reset while iter=3.
    send(16, 0, 16, 0, 0, 0, 0);
    tick(); tick(); tick();
    check("rst_pre_alu_zr", alu_zr, 22);
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    tick();
    rst_n = 1'b1;
    send(-128, 0, 16, 1, 1, 3, 1);
    send(0, 0, 16, 16, 0, 17, 1);

    for (int i = 0; i < 100 && (exp_q.size() != 0 || !in_ready); i++) tick();
    tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("final_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
# mandelbrot_iter_ctrl

Sequential iteration engine that drives the combinational `mandelbrot_alu` step unit and consumes its results. It has four jobs:
- accept one pixel coordinate c;
- feed z and c to the ALU each cycle, starting from z = 0;
- register the returned z;
- count iterations until escape (ALU `size` or `overflow`) or until the iteration limit.

It sits between the pixel scanner (upstream) and the colour mapper (downstream), with a valid/ready handshake on both sides.

## Interface
Parameters:
- WIDTH, 8, width of all fixed-point values, signed format 2.(WIDTH-2)
- ITER_W, 8, width of iteration limit and count

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has a coordinate
- in_ready  out  1  block can accept a coordinate
- in_cr, in_ci  in  WIDTH  coordinate c, signed 2.(WIDTH-2)
- in_max_iter  in  ITER_W  iteration limit, latched on accept
- abort  in  1  synchronous abandon of current pixel
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_count  out  ITER_W  iterations performed
- out_escaped  out  1  1 = escaped, 0 = hit limit
- alu_cr, alu_ci, alu_zr, alu_zi  out  WIDTH  operands to ALU
- alu_zr_next, alu_zi_next  in  WIDTH  ALU results
- alu_size, alu_overflow  in  1  ALU escape flags

## Operation
States:
- IDLE: in_ready=1.
  - On in_valid: latch c and max_iter, clear z and iter.
  - If max_iter==0, go to DONE with count=0, escaped=0.
  - Otherwise go to ITER.
- ITER: each cycle, evaluate the ALU on registered z and c. Escape = alu_size | alu_overflow.
  - Escape: go to DONE, count=iter, escaped=1; z is not updated.
  - Else if iter == max_iter-1: go to DONE, count=max_iter, escaped=0.
  - Else: z <= alu_*_next, iter <= iter+1.
- DONE: out_valid=1.
  - out_count and out_escaped are held stable until out_valid & out_ready; then go to IDLE.
  - in_ready=0 in DONE (no back-to-back overlap).

Other rules:
- abort in ITER or DONE: go to IDLE next edge; no result is emitted; out_valid drops. abort in IDLE is ignored.
- alu_cr/alu_ci = latched c; alu_zr/alu_zi = z registers. Values are passed bit-exact; this block does no arithmetic on them.
- iter is ITER_W bits and never wraps, because it stops at max_iter-1.
- Reset (any time, including mid-ITER or DONE):
  - state=IDLE, out_valid=0, out_count=0, out_escaped=0;
  - z, c, iter, max_iter registers = 0;
  - in_ready=1 once reset is deasserted.

## Timing
- Accept edge = cycle 0. ITER with iter=k occupies cycle k+1.
- Escape detected at iter=k: out_valid rises at cycle k+2.
- No escape, limit M>0: out_valid rises at cycle M+1, count=M.
- max_iter=0: out_valid rises at cycle 1.
- Throughput: one pixel per (iterations + 2) cycles minimum, plus downstream stall.
- All outputs are registered or decoded from state only; there is no combinational in→out path except through the ALU loop.

## Structure
- Shared package `mandelbrot_pkg` holds:
  - state encoding (IDLE, ITER, DONE);
  - fixed-point constants FRAC_BITS = WIDTH-2 and ONE = 1<<(WIDTH-2).
- No sub-module inside. The parent instantiates `mandelbrot_alu` beside this block and wires the alu_* ports.
- Optional: a small `mandelbrot_iter_counter` (counter + limit compare) is acceptable if it keeps the FSM file readable.

## Test plan
WIDTH=8, so 1.0 = 64. Each scenario runs with `mandelbrot_alu` attached.
- c=(0,0), max_iter=16 -> never escapes; out_valid at cycle 17, out_count=16, out_escaped=0.
- c=(64,0) (1.0) -> iter1 overflows (z2=2.0); out_valid at cycle 3, out_count=1, out_escaped=1.
- c=(-128,0) (-2.0) -> iter1: size not set (|z|²=4 is not >4), overflow set; out_count=1, out_escaped=1.
- max_iter=0, any c -> out_valid at cycle 1, out_count=0, out_escaped=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored; then one-cycle handshake -> IDLE next cycle.
- abort at iter=3, and separately rst_n low at iter=3 -> IDLE with no out_valid pulse, all outputs 0; the next pixel runs correctly from z=0.
